// File: rtl/regfile_pkg.sv
// Shared widths, writeback request type and controller state encoding
// for the register-file write-port controller.
package regfile_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREGS  = 1 << ADDR_W;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_req_t;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } ctrl_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester arbiter. With ROUND_ROBIN set, contended grants alternate
// starting with A; otherwise A always wins a contention.
module rr_arb2 #(
    parameter int ROUND_ROBIN = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic req_a,
    input  logic req_b,
    output logic grant_a,
    output logic grant_b
);

    logic prio_b;
    logic contend;

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; an unassigned path would infer a latch.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        contend = enable & req_a & req_b;
        if (contend) begin
            if ((ROUND_ROBIN != 0) && prio_b) grant_b = 1'b1;
            else                              grant_a = 1'b1;
        end else if (enable) begin
            grant_a = req_a;
            grant_b = req_b;
        end
    end

    // Only contended grants move the pointer; after A wins, B is preferred.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            prio_b <= 1'b0;
        else if ((ROUND_ROBIN != 0) && contend)
            prio_b <= grant_a;
    end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Register-file write-port controller: post-reset clear sequencing, A/B
// writeback arbitration onto one write port, and a pending-write scoreboard.
module regfile_wb_ctrl
    import regfile_pkg::wb_req_t, regfile_pkg::ctrl_state_t,
           regfile_pkg::INIT, regfile_pkg::RUN;
#(
    parameter int DATA_W      = regfile_pkg::DATA_W,
    parameter int ADDR_W      = regfile_pkg::ADDR_W,
    parameter int NREGS       = regfile_pkg::NREGS,
    parameter int ROUND_ROBIN = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_rd,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_rd,
    input  logic [DATA_W-1:0] b_data,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_rd,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    output logic              rs1_busy,
    output logic              rs2_busy,
    output logic              rf_enable,
    output logic              rf_reset,
    output logic              rf_rw,
    output logic [ADDR_W-1:0] rf_rd,
    output logic [DATA_W-1:0] rf_din
);

    ctrl_state_t      state;
    ctrl_state_t      state_next;
    logic             run;
    logic             grant_a;
    logic             grant_b;
    wb_req_t          a_req;
    wb_req_t          b_req;
    wb_req_t          win;
    logic [NREGS-1:0] mask;
    logic [NREGS-1:0] mask_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= INIT;
        else       state <= state_next;
    end

    // INIT holds exactly one post-reset cycle, long enough for the register
    // file to see one clearing negedge.
    always_comb begin
        state_next = state;
        case (state)
            INIT:    state_next = RUN;
            RUN:     state_next = RUN;
            default: state_next = INIT;
        endcase
    end

    assign run       = (state == RUN);
    assign rf_enable = 1'b1;
    assign rf_reset  = (state == INIT);

    rr_arb2 #(
        .ROUND_ROBIN(ROUND_ROBIN)
    ) u_arb (
        .clk    (clk),
        .reset  (reset),
        .enable (run),
        .req_a  (a_valid),
        .req_b  (b_valid),
        .grant_a(grant_a),
        .grant_b(grant_b)
    );

    assign a_ready = grant_a;
    assign b_ready = grant_b;

    always_comb begin
        a_req       = '{valid: a_valid, rd: a_rd, data: a_data};
        b_req       = '{valid: b_valid, rd: b_rd, data: b_data};
        win         = grant_b ? b_req : a_req;
        win.valid   = grant_a | grant_b;
    end

    // Writes to x0 are accepted and latched but never strobe the register file.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rf_rw  <= 1'b0;
            rf_rd  <= '0;
            rf_din <= '0;
        end else if (win.valid) begin
            rf_rw  <= (win.rd != '0);
            rf_rd  <= win.rd;
            rf_din <= win.data;
        end else begin
            rf_rw  <= 1'b0;
        end
    end

    // Set is applied after clear so a same-cycle issue and retire of one
    // register leaves the newer producer outstanding.
    always_comb begin
        mask_next = mask;
        if (win.valid)
            mask_next[win.rd] = 1'b0;
        if (run && issue_valid)
            mask_next[issue_rd] = 1'b1;
        mask_next[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) mask <= '0;
        else       mask <= mask_next;
    end

    assign rs1_busy = mask[rs1];
    assign rs2_busy = mask[rs2];

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed bench for regfile_wb_ctrl: one round-robin instance and one
// fixed-priority instance, plus a behavioural register file on the write port.
module tb_regfile_wb_ctrl;
    import regfile_pkg::*;

    logic              clk;
    logic              reset;
    logic              issue_valid;
    logic [ADDR_W-1:0] issue_rd;
    logic [ADDR_W-1:0] rs1;
    logic [ADDR_W-1:0] rs2;

    // round-robin instance
    logic              a_valid, a_ready, b_valid, b_ready;
    logic [ADDR_W-1:0] a_rd, b_rd, rf_rd;
    logic [DATA_W-1:0] a_data, b_data, rf_din;
    logic              rs1_busy, rs2_busy, rf_enable, rf_reset, rf_rw;

    // fixed-priority instance
    logic              z_a_valid, z_a_ready, z_b_valid, z_b_ready;
    logic [ADDR_W-1:0] z_a_rd, z_b_rd, z_rf_rd;
    logic [DATA_W-1:0] z_a_data, z_b_data, z_rf_din;
    logic              z_rs1_busy, z_rs2_busy, z_rf_enable, z_rf_reset, z_rf_rw;

    logic [DATA_W-1:0] rf_mem [NREGS];

    int tests = 0;
    int fails = 0;

    logic [ADDR_W-1:0] exp_rr [5] = '{5'd1, 5'd9, 5'd2, 5'd10, 5'd3};
    logic [ADDR_W-1:0] exp_fx [5] = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd9};

    regfile_wb_ctrl #(.ROUND_ROBIN(1)) dut (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .rs1(rs1), .rs2(rs2),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .rf_enable(rf_enable), .rf_reset(rf_reset), .rf_rw(rf_rw),
        .rf_rd(rf_rd), .rf_din(rf_din)
    );

    regfile_wb_ctrl #(.ROUND_ROBIN(0)) dut0 (
        .clk(clk), .reset(reset),
        .a_valid(z_a_valid), .a_ready(z_a_ready), .a_rd(z_a_rd), .a_data(z_a_data),
        .b_valid(z_b_valid), .b_ready(z_b_ready), .b_rd(z_b_rd), .b_data(z_b_data),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .rs1(rs1), .rs2(rs2),
        .rs1_busy(z_rs1_busy), .rs2_busy(z_rs2_busy),
        .rf_enable(z_rf_enable), .rf_reset(z_rf_reset), .rf_rw(z_rf_rw),
        .rf_rd(z_rf_rd), .rf_din(z_rf_din)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Register file model driven by the round-robin instance: clears and
    // writes on the negedge inside the strobe cycle.
    always @(negedge clk) begin
        if (rf_enable) begin
            if (rf_reset) begin
                for (int i = 0; i < NREGS; i++) rf_mem[i] <= '0;
            end else if (rf_rw) begin
                rf_mem[rf_rd] <= rf_din;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int ai, bi, zai, zbi;
        logic ga, gb, zga, zgb;

        reset = 1'b1;
        issue_valid = 1'b0; issue_rd = '0; rs1 = '0; rs2 = '0;
        a_valid = 1'b0; a_rd = '0; a_data = '0;
        b_valid = 1'b0; b_rd = '0; b_data = '0;
        z_a_valid = 1'b0; z_a_rd = '0; z_a_data = '0;
        z_b_valid = 1'b0; z_b_rd = '0; z_b_data = '0;

        // reset held three cycles, then one INIT cycle
        repeat (3) tick();
        check("reset_rf_reset", rf_reset, 1'b1);
        check("reset_rf_enable", rf_enable, 1'b1);
        check("reset_rf_rw", rf_rw, 1'b0);
        reset = 1'b0;
        a_valid = 1'b1; a_rd = 5'd3; a_data = 32'h1111_1111;
        issue_valid = 1'b1; issue_rd = 5'd3; rs1 = 5'd3;
        #1;
        check("init_rf_reset", rf_reset, 1'b1);
        check("init_a_ready", a_ready, 1'b0);
        check("init_z_rf_reset", z_rf_reset, 1'b1);
        a_valid = 1'b0; issue_valid = 1'b0;
        tick();
        check("run_rf_reset", rf_reset, 1'b0);
        check("run_rf_rw", rf_rw, 1'b0);
        check("init_issue_ignored", rs1_busy, 1'b0);
        check("rf_clear_r0", rf_mem[0], 32'h0);
        check("rf_clear_r5", rf_mem[5], 32'h0);
        check("rf_clear_r31", rf_mem[31], 32'h0);

        // single write from A
        a_valid = 1'b1; a_rd = 5'd5; a_data = 32'hDEAD_BEEF;
        #1;
        check("a_only_ready", a_ready, 1'b1);
        check("a_only_b_ready", b_ready, 1'b0);
        tick();
        a_valid = 1'b0;
        check("a_only_rf_rw", rf_rw, 1'b1);
        check("a_only_rf_rd", rf_rd, 5'd5);
        check("a_only_rf_din", rf_din, 32'hDEAD_BEEF);
        tick();
        check("a_only_rw_drop", rf_rw, 1'b0);
        check("a_only_rd_hold", rf_rd, 5'd5);
        check("a_only_rf_mem5", rf_mem[5], 32'hDEAD_BEEF);

        // contention on both instances; each source holds until accepted
        ai = 0; bi = 0; zai = 0; zbi = 0;
        for (int c = 0; c < 5; c++) begin
            a_valid = (ai < 4); a_rd = 5'(1 + ai); a_data = 32'hA000_0000 | 32'(1 + ai);
            b_valid = (bi < 4); b_rd = 5'(9 + bi); b_data = 32'hB000_0000 | 32'(9 + bi);
            z_a_valid = (zai < 4); z_a_rd = 5'(1 + zai); z_a_data = 32'hA000_0000 | 32'(1 + zai);
            z_b_valid = (zbi < 4); z_b_rd = 5'(9 + zbi); z_b_data = 32'hB000_0000 | 32'(9 + zbi);
            #1;
            ga = a_ready; gb = b_ready; zga = z_a_ready; zgb = z_b_ready;
            tick();
            check($sformatf("rr_order%0d_rd", c), rf_rd, exp_rr[c]);
            check($sformatf("rr_order%0d_din", c), rf_din,
                  (exp_rr[c] < 5'd9 ? 32'hA000_0000 : 32'hB000_0000) | 32'(exp_rr[c]));
            check($sformatf("fx_order%0d_rd", c), z_rf_rd, exp_fx[c]);
            check($sformatf("fx_order%0d_din", c), z_rf_din,
                  (exp_fx[c] < 5'd9 ? 32'hA000_0000 : 32'hB000_0000) | 32'(exp_fx[c]));
            if (ga) ai++;
            if (gb) bi++;
            if (zga) zai++;
            if (zgb) zbi++;
        end
        a_valid = 1'b0; b_valid = 1'b0; z_a_valid = 1'b0; z_b_valid = 1'b0;
        tick();

        // scoreboard set, clear, and same-cycle set-wins
        issue_valid = 1'b1; issue_rd = 5'd7; rs1 = 5'd7;
        #1;
        check("sb_not_yet_busy", rs1_busy, 1'b0);
        tick();
        issue_valid = 1'b0;
        check("sb_issue_busy", rs1_busy, 1'b1);
        check("sb_issue_busy_fx", z_rs1_busy, 1'b1);
        b_valid = 1'b1; b_rd = 5'd7; b_data = 32'h0000_0077;
        #1;
        check("sb_b_ready", b_ready, 1'b1);
        tick();
        b_valid = 1'b0;
        check("sb_retire_clear", rs1_busy, 1'b0);
        check("sb_retire_rf_rd", rf_rd, 5'd7);
        issue_valid = 1'b1; issue_rd = 5'd7;
        tick();
        check("sb_reissue_busy", rs1_busy, 1'b1);
        b_valid = 1'b1; b_rd = 5'd7; b_data = 32'h0000_0078;
        tick();
        issue_valid = 1'b0; b_valid = 1'b0;
        check("sb_set_wins", rs1_busy, 1'b1);
        check("sb_set_wins_rw", rf_rw, 1'b1);

        // writes and issues to x0
        a_valid = 1'b1; a_rd = 5'd0; a_data = 32'h0000_1234;
        issue_valid = 1'b1; issue_rd = 5'd0; rs2 = 5'd0;
        #1;
        check("x0_a_ready", a_ready, 1'b1);
        tick();
        a_valid = 1'b0; issue_valid = 1'b0;
        check("x0_no_rw", rf_rw, 1'b0);
        check("x0_not_busy", rs2_busy, 1'b0);

        // build mask 0x880, then reset while B is stalled behind A
        issue_valid = 1'b1; issue_rd = 5'd11; rs2 = 5'd11;
        tick();
        issue_valid = 1'b0;
        check("mid_mask", dut.mask, 32'h0000_0880);
        a_valid = 1'b1; a_rd = 5'd2; a_data = 32'h0000_0002;
        b_valid = 1'b1; b_rd = 5'd3; b_data = 32'h0000_0003;
        #1;
        check("mid_b_wins", b_ready, 1'b1);
        tick();
        b_rd = 5'd4; b_data = 32'h0000_0004;
        #1;
        check("mid_a_wins", a_ready, 1'b1);
        check("mid_b_stalled", b_ready, 1'b0);
        check("mid_rw_pending", rf_rw, 1'b1);
        reset = 1'b1;
        #1;
        check("rst_rw_drop", rf_rw, 1'b0);
        check("rst_mask_clear", dut.mask, 32'h0);
        check("rst_rs1_busy", rs1_busy, 1'b0);
        check("rst_rs2_busy", rs2_busy, 1'b0);
        check("rst_init", rf_reset, 1'b1);
        check("rst_b_ready", b_ready, 1'b0);
        a_valid = 1'b0; b_valid = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        check("rel_run", rf_reset, 1'b0);
        check("rel_no_rw", rf_rw, 1'b0);
        tick();
        check("rel_no_rw2", rf_rw, 1'b0);
        check("rel_rf_mem3", rf_mem[3], 32'h0);
        check("rel_rf_mem5", rf_mem[5], 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
